// File: rtl/dice_pkg.sv
// ---------------------------------------------------------------------------
// dice_pkg
// Shared types and helpers for the dice roll scheduler:
//   - state_e      : roll engine FSM states
//   - GLYPH_* / DASH : 7-segment patterns, bit order g..a, 1 = lit
//   - dice_map     : 3 random bits -> die face 1..6
//   - glyph_of     : die face -> segment pattern (0 or out of range -> dash)
//   - lfsr_next    : one step of the 16-bit Galois LFSR used as entropy
// ---------------------------------------------------------------------------
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] DASH    = 7'b1000000;

    // Values 6 and 7 fold onto 2 and 3 so the result is always a legal face.
    function automatic logic [2:0] dice_map(input logic [2:0] r);
        logic [2:0] face;
        case (r)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: face = r + 3'd1;
            3'd6:    face = 3'd2;
            3'd7:    face = 3'd3;
            default: face = 3'd1;
        endcase
        return face;
    endfunction

    function automatic logic [6:0] glyph_of(input logic [2:0] v);
        logic [6:0] seg;
        case (v)
            3'd1:    seg = GLYPH_1;
            3'd2:    seg = GLYPH_2;
            3'd3:    seg = GLYPH_3;
            3'd4:    seg = GLYPH_4;
            3'd5:    seg = GLYPH_5;
            3'd6:    seg = GLYPH_6;
            default: seg = DASH;
        endcase
        return seg;
    endfunction

    // Right shift; bit 0 feeds back into bit 15 and is XORed into taps 13, 12, 10.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0], s[15], s[14] ^ s[0], s[13] ^ s[0], s[12], s[11] ^ s[0], s[10:1]};
    endfunction

endpackage

// File: rtl/dice_roll_scheduler_if.sv
// ---------------------------------------------------------------------------
// dice_roll_scheduler_if
// Board-side signal bundle of the dice roll scheduler.
//   req_i          : raw button levels, one per player
//   grant_o        : one-hot owner of the roll engine, 0 when idle
//   busy_o         : roll in progress
//   result_valid_o : player holds a completed result
//   seg_o / dp_o   : segments g..a and decimal point of the selected digit
//   digit_sel_o    : one-hot active-high digit enable
//   sum_o          : sum of valid results (only when DICE_SUM_EN is defined)
// slave modport = scheduler side, master modport = board side.
// ---------------------------------------------------------------------------
interface dice_roll_scheduler_if #(
    parameter int NUM_PLAYERS = 4
);
    logic [NUM_PLAYERS-1:0] req_i;
    logic [NUM_PLAYERS-1:0] grant_o;
    logic                   busy_o;
    logic [NUM_PLAYERS-1:0] result_valid_o;
    logic [6:0]             seg_o;
    logic                   dp_o;
    logic [NUM_PLAYERS-1:0] digit_sel_o;
`ifdef DICE_SUM_EN
    logic [7:0]             sum_o;

    modport slave  (input req_i, output grant_o, busy_o, result_valid_o,
                    seg_o, dp_o, digit_sel_o, sum_o);
    modport master (output req_i, input grant_o, busy_o, result_valid_o,
                    seg_o, dp_o, digit_sel_o, sum_o);
`else
    modport slave  (input req_i, output grant_o, busy_o, result_valid_o,
                    seg_o, dp_o, digit_sel_o);
    modport master (output req_i, input grant_o, busy_o, result_valid_o,
                    seg_o, dp_o, digit_sel_o);
`endif
endinterface

// File: rtl/dice_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dice_rr_arbiter
// Combinational round-robin pick: the first pending requester found when
// scanning upward (with wrap) from ptr_i.
//   pending_i : pending request vector
//   ptr_i     : index searched first
//   grant_o   : one-hot winner, 0 when nothing pending
//   idx_o     : binary index of the winner
//   found_o   : at least one request pending
// ---------------------------------------------------------------------------
module dice_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    localparam int SW = IDX_W + 1;

    // Rotating priority scan; the sum is one bit wider so the wrap needs no modulo.
    always_comb begin
        logic [SW-1:0]    sum_v;
        logic [IDX_W-1:0] cand_v;
        grant_o = {N{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum_v = {1'b0, ptr_i} + SW'(i);
            if (sum_v >= SW'(N)) begin
                sum_v = sum_v - SW'(N);
            end else begin
                sum_v = sum_v;
            end
            cand_v = sum_v[IDX_W-1:0];
            if (!found_o && pending_i[cand_v]) begin
                found_o         = 1'b1;
                idx_o           = cand_v;
                grant_o[cand_v] = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end
endmodule

// File: rtl/dice_roll_scheduler.sv
// ---------------------------------------------------------------------------
// dice_roll_scheduler
// Shares one dice-roll engine (16-bit LFSR, 1..6 mapper, slowing roll
// animation) between NUM_PLAYERS push buttons, keeps one result per player
// and time-multiplexes a single 7-segment driver across the player digits.
//   wb_clk_i : sole clock
//   wb_rst_i : asynchronous active-high reset
//   bus      : dice_roll_scheduler_if.slave (buttons in, grant/busy/
//              result_valid/seg/dp/digit_sel out)
// Optional: define DICE_SUM_EN to add bus.sum_o, the registered sum of all
// valid results.
// ---------------------------------------------------------------------------
module dice_roll_scheduler
    import dice_pkg::*;
#(
    parameter int          NUM_PLAYERS = 4,
    parameter int          PRESCALE    = 1024,
    parameter int          ROLL_STEPS  = 8,
    parameter logic [15:0] LFSR_SEED   = 16'h00DA
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    dice_roll_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PLAYERS);
    localparam int PW    = $clog2(PRESCALE);
    localparam int SW    = $clog2(ROLL_STEPS + 2);

    state_e                 state_r, state_next_s;
    logic [PW-1:0]          presc_r;
    logic                   tick_s;
    logic [15:0]            lfsr_r;
    logic [15:0]            rc_r;
    logic [2:0]             rand_lo_s;
    logic [NUM_PLAYERS-1:0] sync1_r, sync2_r, prev_r, edge_s;
    logic [NUM_PLAYERS-1:0] pending_r;
    logic [NUM_PLAYERS-1:0] grant_r;
    logic [IDX_W-1:0]       owner_r, ptr_r;
    logic [SW-1:0]          step_r, wait_r;
    logic [2:0]             anim_r;
    logic [2:0]             results_r [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] valid_r;
    logic                   busy_r;
    logic [NUM_PLAYERS-1:0] arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_found_s;
    logic                   do_grant_s, do_step_s, do_finish_s, do_release_s, do_wait_s;
    logic [IDX_W-1:0]       scan_r, scan_next_s;
    logic [2:0]             disp_val_s;
    logic                   disp_dp_s;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic [NUM_PLAYERS-1:0] digsel_r;

    assign tick_s = (presc_r == PW'(PRESCALE - 1));
    // Only the low three bits of lfsr + rc reach the mapper; carries never move downward.
    assign rand_lo_s = lfsr_r[2:0] + rc_r[2:0];
    assign edge_s    = sync2_r & ~prev_r;

    // Prescaler, LFSR and roll counter; all free-running from reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc_r <= {PW{1'b0}};
            lfsr_r  <= LFSR_SEED;
            rc_r    <= 16'd0;
        end else begin
            presc_r <= presc_r + PW'(1);
            if (tick_s) begin
                lfsr_r <= lfsr_next(lfsr_r);
                rc_r   <= rc_r + 16'd1;
            end
        end
    end

    // Button synchronizers and rising-edge history.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_r <= {NUM_PLAYERS{1'b0}};
            sync2_r <= {NUM_PLAYERS{1'b0}};
            prev_r  <= {NUM_PLAYERS{1'b0}};
        end else begin
            sync1_r <= bus.req_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    dice_rr_arbiter #(
        .N     (NUM_PLAYERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending_i (pending_r),
        .ptr_i     (ptr_r),
        .grant_o   (arb_grant_s),
        .idx_o     (arb_idx_s),
        .found_o   (arb_found_s)
    );

    // FSM next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        do_grant_s   = 1'b0;
        do_step_s    = 1'b0;
        do_finish_s  = 1'b0;
        do_release_s = 1'b0;
        do_wait_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_found_s) begin
                    state_next_s = ROLL;
                    do_grant_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROLL: begin
                // Step k lasts k+2 ticks, so the animation visibly slows down.
                if (tick_s && (wait_r == step_r + SW'(1))) begin
                    do_step_s = 1'b1;
                    if (step_r == SW'(ROLL_STEPS - 1)) begin
                        do_finish_s  = 1'b1;
                        state_next_s = HOLD;
                    end else begin
                        state_next_s = ROLL;
                    end
                end else if (tick_s) begin
                    do_wait_s = 1'b1;
                end else begin
                    state_next_s = ROLL;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                    do_release_s = 1'b1;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register and registered busy flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Pending requests: owner edges are dropped, a new edge survives a same-cycle grant clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending_r <= {NUM_PLAYERS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~(do_grant_s ? arb_grant_s : {NUM_PLAYERS{1'b0}}))
                       | (edge_s & ~grant_r);
        end
    end

    // Roll engine: ownership, animation steps, result storage, arbitration pointer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant_r <= {NUM_PLAYERS{1'b0}};
            owner_r <= {IDX_W{1'b0}};
            ptr_r   <= {IDX_W{1'b0}};
            step_r  <= {SW{1'b0}};
            wait_r  <= {SW{1'b0}};
            anim_r  <= 3'd0;
            valid_r <= {NUM_PLAYERS{1'b0}};
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                results_r[i] <= 3'd0;
            end
        end else begin
            if (do_grant_s) begin
                grant_r <= arb_grant_s;
                owner_r <= arb_idx_s;
                step_r  <= {SW{1'b0}};
                wait_r  <= {SW{1'b0}};
                anim_r  <= 3'd0;
                valid_r <= valid_r & ~arb_grant_s;
            end
            if (do_wait_s) begin
                wait_r <= wait_r + SW'(1);
            end
            if (do_step_s) begin
                anim_r <= dice_map(rand_lo_s);
                step_r <= step_r + SW'(1);
                wait_r <= {SW{1'b0}};
            end
            if (do_finish_s) begin
                results_r[owner_r] <= dice_map(rand_lo_s);
                valid_r[owner_r]   <= 1'b1;
            end
            if (do_release_s) begin
                grant_r <= {NUM_PLAYERS{1'b0}};
                ptr_r   <= (owner_r == IDX_W'(NUM_PLAYERS - 1)) ? IDX_W'(0) : owner_r + IDX_W'(1);
            end
        end
    end

    // Scan index for the next cycle and the value the selected digit should show.
    always_comb begin
        scan_next_s = scan_r;
        disp_val_s  = 3'd0;
        disp_dp_s   = 1'b0;
        if (tick_s) begin
            scan_next_s = (scan_r == IDX_W'(NUM_PLAYERS - 1)) ? IDX_W'(0) : scan_r + IDX_W'(1);
        end else begin
            scan_next_s = scan_r;
        end
        if ((state_r == ROLL) && (scan_next_s == owner_r)) begin
            disp_val_s = anim_r;
            disp_dp_s  = 1'b1;
        end else if (valid_r[scan_next_s]) begin
            disp_val_s = results_r[scan_next_s];
        end else begin
            disp_val_s = 3'd0;
        end
    end

    // Display registers: digit select, segments and dp update together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scan_r   <= {IDX_W{1'b0}};
            digsel_r <= NUM_PLAYERS'(1);
            seg_r    <= DASH;
            dp_r     <= 1'b0;
        end else begin
            scan_r   <= scan_next_s;
            digsel_r <= NUM_PLAYERS'(1) << scan_next_s;
            seg_r    <= glyph_of(disp_val_s);
            dp_r     <= disp_dp_s;
        end
    end

`ifdef DICE_SUM_EN
    logic [7:0] sum_s, sum_r;

    // Sum of all currently valid results.
    always_comb begin
        sum_s = 8'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (valid_r[i]) begin
                sum_s = sum_s + 8'(results_r[i]);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Registered sum, follows result writes by one cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sum_r <= 8'd0;
        end else begin
            sum_r <= sum_s;
        end
    end

    assign bus.sum_o = sum_r;
`endif

    assign bus.grant_o        = grant_r;
    assign bus.busy_o         = busy_r;
    assign bus.result_valid_o = valid_r;
    assign bus.seg_o          = seg_r;
    assign bus.dp_o           = dp_r;
    assign bus.digit_sel_o    = digsel_r;

endmodule

// File: doc/dice_roll_scheduler.md
Name: dice_roll_scheduler

Overview:
Shares one dice-roll engine (16-bit LFSR, 1..6 mapper, slowing roll animation) between NUM_PLAYERS push-button requesters.
- Round-robin arbitration over button presses; runs one roll at a time.
- Stores a 1..6 result per player.
- Time-multiplexes a single 7-segment driver across the per-player digits.
- Sits between board button inputs and the 7-seg/digit-select pads of the misc-stuff macro.

Parameters:
NUM_PLAYERS, 4, number of requesters/digits (2..8)
PRESCALE, 1024, wb_clk_i cycles per tick (power of two, >=4)
ROLL_STEPS, 8, animation updates per roll (>=1)
LFSR_SEED, 16'h00DA, LFSR reset value (must be nonzero)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  asynchronous, active-high reset
req_i  in  NUM_PLAYERS  raw button levels, one per player
grant_o  out  NUM_PLAYERS  one-hot owner of the roll engine, 0 when idle
busy_o  out  1  roll in progress (ROLL or HOLD)
result_valid_o  out  NUM_PLAYERS  player holds a completed result
seg_o  out  7  segments g..a for the selected digit, 1 = lit
dp_o  out  1  decimal point, 1 = selected digit is the rolling player
digit_sel_o  out  NUM_PLAYERS  one-hot active-high digit enable

Behaviour:
- Reset (async, wb_rst_i=1):
  - state=IDLE, grant_o=0, busy_o=0, result_valid_o=0, all results=0, pending=0.
  - lfsr=LFSR_SEED, prescaler=0, scan index=0, digit_sel_o=1, seg_o=7'b1000000 (dash), dp_o=0.
  - Reset mid-roll aborts the roll with no result written.
- Tick: 1-cycle pulse when the prescaler wraps from PRESCALE-1 to 0. First tick occurs PRESCALE cycles after reset release.
- LFSR: advances every tick.
  - Shift right; new[15]=old[0]; bits 13, 12 and 10 take old[14], old[13] and old[11] XOR old[0]; other bits shift unchanged.
  - Roll counter rc (16 bit) increments every tick; random = lfsr + rc, mod 2^16.
- Dice map, r = random[2:0]: r<=5 gives r+1; r=6 gives 2; r=7 gives 3. Result is always 1..6.
- Inputs:
  - Each req_i bit passes a 2-FF synchronizer, then rising-edge detection.
  - An edge sets pending[i] 3 cycles after the input rises.
  - An edge from the current owner is dropped.
  - An edge on an already-pending bit has no additional effect.
- Arbitration: round-robin starting at the player after the last granted; the pointer is 0 after reset. Evaluated only in IDLE.
- FSM:
  - IDLE -> ROLL when pending != 0. In the same edge: grant_o = one-hot winner, clear pending[winner], clear result_valid[winner], step=0, wait=0.
  - ROLL, on each tick: wait++.
    - When wait == step+2: anim value = map(random), step++, wait=0.
    - The update with step == ROLL_STEPS-1 also writes result[owner] = that value, sets result_valid[owner] and moves to HOLD.
    - Roll length: sum over k=0..ROLL_STEPS-1 of (k+2) ticks; 44 for default ROLL_STEPS=8.
  - HOLD -> IDLE on the next tick. grant_o is cleared and the arbitration pointer updated on that edge.
- Display:
  - Scan index advances modulo NUM_PLAYERS on each tick; digit_sel_o = one-hot(index).
  - seg_o shows the anim value if index == owner and the state is ROLL; otherwise result[index] if valid, else dash.
  - anim value is 0 before the first step of a roll; 0 displays as dash.
  - Digit glyphs (g..a): 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101.
  - Segment, dp and digit outputs are registered and change together.

Optional Feature:
DICE_SUM_EN:
- Defined: adds output sum_o [7:0], the registered sum of result[i] over all valid players, updated the cycle after any result write. Reset value 0.
- Undefined: port and logic absent.

Decomposition:
- Package dice_pkg holds:
  - state enum (IDLE, ROLL, HOLD)
  - glyph constants, including DASH = 7'b1000000
  - function dice_map(3-bit) -> 3-bit
- One natural sub-module: dice_rr_arbiter (pending vector + pointer -> one-hot grant).

Test Plan:
All scenarios use PRESCALE=4, NUM_PLAYERS=4, ROLL_STEPS=8.
- Reset: assert wb_rst_i mid-cycle -> outputs reach reset values immediately; digit_sel_o=4'b0001, seg_o=7'b1000000; first tick 4 cycles after release.
- Single roll: pulse req_i[2] -> grant_o=4'b0100 at cycle 4 after the rise; busy for 44 ticks + 1 HOLD tick; result_valid_o=4'b0100; result in 1..6 and matching a bit-exact LFSR reference model.
- Simultaneous: req_i=4'b1011 in the same cycle after reset -> grants in order 0, 1, 3, each exactly once.
- Owner re-press: player 1 presses again during its own roll -> edge dropped; no second roll.
- Another player presses during a roll -> pending, served immediately after HOLD.
- Display scan: over 4 ticks, digit_sel_o sequences 0001, 0010, 0100, 1000. Players without results show dash; the rolling player shows the anim value with dp_o=1.
- DICE_SUM_EN: results 3 and 5 on players 0 and 2 -> sum_o=8. A re-roll of player 0 clears its valid bit at grant, so sum_o=5 during the roll.
